// File: rtl/keccak_x_heep_pkg.sv
// Shared constants and types for the Keccak buffer in the x_heep external subsystem.
package keccak_x_heep_pkg;

    localparam int unsigned NWORDS_DEFAULT = 50;

    typedef enum logic [0:0] {
        LOC_PRIO = 1'b0,
        OBI_PRIO = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } resp_stage_t;

    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI bus request/response structs shared across the external subsystem.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/keccak_obi_resp_pipe.sv
// Fixed-latency {valid, data} shift register for OBI responses; reset flushes all stages.
module keccak_obi_resp_pipe
    import keccak_x_heep_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  resp_stage_t in_stage,
    output resp_stage_t out_stage
);

    resp_stage_t stage_q [LATENCY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_stage;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_stage = stage_q[LATENCY-1];

endmodule

// File: rtl/keccak_obi_resp_buf.sv
// OBI responder for the Keccak state buffer, shared with a local datapath port.
// Optional perf counters enabled by defining KECCAK_OBI_RESP_PERF_EN.
module keccak_obi_resp_buf
    import keccak_x_heep_pkg::*;
    import obi_pkg::*;
#(
    parameter int unsigned NWORDS       = NWORDS_DEFAULT,
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  obi_req_t                  slave_req_i,
    output obi_resp_t                 slave_resp_o,
    input  logic                      loc_req_i,
    input  logic                      loc_we_i,
    input  logic [$clog2(NWORDS)-1:0] loc_addr_i,
    input  logic [31:0]               loc_wdata_i,
    output logic                      loc_gnt_o,
    output logic [31:0]               loc_rdata_o,
    output logic                      oor_o
`ifdef KECCAK_OBI_RESP_PERF_EN
   ,output logic [31:0]               perf_obi_acc_o,
    output logic [31:0]               perf_obi_stall_o,
    output logic [15:0]               perf_starve_o
`endif
);

    localparam int unsigned AW = $clog2(NWORDS);
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    logic [31:0]   mem [NWORDS];
    logic [AW-1:0] obi_idx;
    logic          obi_req;
    logic          obi_oor;
    logic          loc_oor;
    logic          obi_gnt;
    logic          loc_gnt;
    logic          obi_hs;
    logic          unused_addr;

    arb_state_e    state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          prio_enter;

    resp_stage_t   pipe_in;
    resp_stage_t   pipe_out;

    assign obi_req     = slave_req_i.req;
    assign obi_idx     = slave_req_i.addr[AW+1:2];
    assign unused_addr = ^{slave_req_i.addr[31:AW+2], slave_req_i.addr[1:0]};
    assign obi_oor     = 32'(obi_idx) >= NWORDS;
    assign loc_oor     = 32'(loc_addr_i) >= NWORDS;
    assign obi_hs      = obi_req & obi_gnt;

    always_comb begin
        obi_gnt = 1'b0;
        loc_gnt = 1'b0;
        if (state_q == OBI_PRIO) begin
            obi_gnt = obi_req;
            loc_gnt = loc_req_i & ~obi_req;
        end else begin
            loc_gnt = loc_req_i;
            obi_gnt = obi_req & ~loc_req_i;
        end
    end

    // Counter is cleared on entry to OBI_PRIO; OBI_PRIO always lasts a single cycle.
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        prio_enter = 1'b0;
        case (state_q)
            LOC_PRIO: begin
                if (obi_gnt) begin
                    starve_d = '0;
                end else if (obi_req) begin
                    if (32'(starve_q) + 32'd1 >= STARVE_LIMIT) begin
                        state_d    = OBI_PRIO;
                        starve_d   = '0;
                        prio_enter = 1'b1;
                    end else begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            OBI_PRIO: begin
                state_d  = LOC_PRIO;
                starve_d = '0;
            end
            default: begin
                state_d  = LOC_PRIO;
                starve_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= LOC_PRIO;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NWORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (obi_hs && slave_req_i.we && !obi_oor) begin
                mem[obi_idx] <= be_merge(mem[obi_idx], slave_req_i.wdata, slave_req_i.be);
            end
            if (loc_gnt && loc_we_i && !loc_oor) begin
                mem[loc_addr_i] <= loc_wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            loc_rdata_o <= '0;
            oor_o       <= 1'b0;
        end else begin
            if (loc_gnt && !loc_we_i) begin
                loc_rdata_o <= loc_oor ? '0 : mem[loc_addr_i];
            end
            if (obi_hs && obi_oor) begin
                oor_o <= 1'b1;
            end
        end
    end

    always_comb begin
        pipe_in       = '0;
        pipe_in.valid = obi_hs;
        if (obi_hs && !slave_req_i.we && !obi_oor) begin
            pipe_in.data = mem[obi_idx];
        end
    end

    keccak_obi_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_stage  (pipe_in),
        .out_stage (pipe_out)
    );

    assign slave_resp_o.gnt    = obi_gnt;
    assign slave_resp_o.rvalid = pipe_out.valid;
    assign slave_resp_o.rdata  = pipe_out.valid ? pipe_out.data : '0;
    assign loc_gnt_o           = loc_gnt;

`ifdef KECCAK_OBI_RESP_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_obi_acc_o   <= '0;
            perf_obi_stall_o <= '0;
            perf_starve_o    <= '0;
        end else begin
            if (obi_hs && perf_obi_acc_o != '1) begin
                perf_obi_acc_o <= perf_obi_acc_o + 1'b1;
            end
            if (obi_req && !obi_gnt && perf_obi_stall_o != '1) begin
                perf_obi_stall_o <= perf_obi_stall_o + 1'b1;
            end
            if (prio_enter && perf_starve_o != '1) begin
                perf_starve_o <= perf_starve_o + 1'b1;
            end
        end
    end
`endif

endmodule
